// File: rtl/rtype_decode_stage_pkg.sv
// Shared definitions for the R-type issue stage: instruction layout, funct codes
// and the legality rule used when deciding whether the ALU may write rd.
package rtype_decode_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int INSTR_W    = 32;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;

    localparam int OPC_LSB   = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_LSB = 0;

    typedef enum logic [5:0] {
        FN_ADD   = 6'b001001,
        FN_SUB   = 6'b001010,
        FN_SHIFT = 6'b100001,
        FN_OR    = 6'b100101
    } funct_e;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } rtype_fields_t;

    function automatic rtype_fields_t unpack_instr(input logic [INSTR_W-1:0] w);
        rtype_fields_t f;
        f.opcode = w[OPC_LSB   +: 6];
        f.rs     = w[RS_LSB    +: 5];
        f.rt     = w[RT_LSB    +: 5];
        f.rd     = w[RD_LSB    +: 5];
        f.shamt  = w[SHAMT_LSB +: 5];
        f.funct  = w[FUNCT_LSB +: 6];
        return f;
    endfunction

    function automatic logic is_legal(input rtype_fields_t f);
        return (f.opcode == OPC_RTYPE) &&
               (f.funct inside {FN_ADD, FN_SUB, FN_SHIFT, FN_OR});
    endfunction

endpackage

// File: rtl/rtype_reg_file.sv
// 2-read / 1-write register file with r0 hardwired to zero.
// Reads are combinational; the write lands at the rising edge.
module rtype_reg_file
    import rtype_decode_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    localparam int NREGS = 2 ** REG_AW;

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rs_data = (rs_addr == '0) ? '0 : mem[rs_addr];
    assign rt_data = (rt_addr == '0) ? '0 : mem[rt_addr];

endmodule

// File: rtl/rtype_decode_stage.sv
// Issue stage ahead of the R-type ALU: decodes the instruction, reads operands with
// write-back bypass and holds them in a single output register for the ALU.
module rtype_decode_stage
    import rtype_decode_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               wb_en,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  Rs_Data,
    output logic [DATA_W-1:0]  Rt_Data,
    output logic [4:0]         shamt,
    output logic [5:0]         funct,
    output logic [REG_AW-1:0]  rd_addr,
    output logic               illegal
);

    rtype_fields_t     f;
    logic              legal;
    logic              accept;
    logic [REG_AW-1:0] rs_a, rt_a;
    logic [DATA_W-1:0] rs_rf, rt_rf;
    logic [DATA_W-1:0] rs_next, rt_next;
    logic [REG_AW-1:0] held_rs, held_rt;
    logic              held_rs_hit, held_rt_hit;

    assign f      = unpack_instr(instr);
    assign legal  = is_legal(f);
    assign rs_a   = REG_AW'(f.rs);
    assign rt_a   = REG_AW'(f.rt);

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    rtype_reg_file #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .rs_addr (rs_a),
        .rt_addr (rt_a),
        .rs_data (rs_rf),
        .rt_data (rt_rf),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    // A write landing on the same edge as the read must be visible to the operand.
    assign rs_next = (wb_en && wb_addr == rs_a && rs_a != '0) ? wb_data : rs_rf;
    assign rt_next = (wb_en && wb_addr == rt_a && rt_a != '0) ? wb_data : rt_rf;

    assign held_rs_hit = wb_en && wb_addr == held_rs && held_rs != '0;
    assign held_rt_hit = wb_en && wb_addr == held_rt && held_rt != '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Rs_Data   <= '0;
            Rt_Data   <= '0;
            shamt     <= '0;
            funct     <= '0;
            rd_addr   <= '0;
            illegal   <= 1'b0;
            held_rs   <= '0;
            held_rt   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            Rs_Data   <= rs_next;
            Rt_Data   <= rt_next;
            shamt     <= f.shamt;
            funct     <= f.funct;
            rd_addr   <= legal ? REG_AW'(f.rd) : '0;
            illegal   <= !legal;
            held_rs   <= rs_a;
            held_rt   <= rt_a;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
            // Stalled: keep held operands coherent with the register file.
            if (held_rs_hit) Rs_Data <= wb_data;
            if (held_rt_hit) Rt_Data <= wb_data;
        end
    end

endmodule

// File: tb/tb_rtype_decode_stage.sv
// Randomized scoreboard bench for rtype_decode_stage with a register-array reference model.
module tb_rtype_decode_stage;

    localparam logic [5:0] F_ADD   = 6'b001001;
    localparam logic [5:0] F_SUB   = 6'b001010;
    localparam logic [5:0] F_SHIFT = 6'b100001;
    localparam logic [5:0] F_OR    = 6'b100101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] Rs_Data, Rt_Data;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [4:0]  rd_addr;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] rs, rt, rd, sh;
        logic [5:0] fn;
        logic       ill;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [31:0] regs [32];

    rtype_decode_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Rs_Data   (Rs_Data),
        .Rt_Data   (Rt_Data),
        .shamt     (shamt),
        .funct     (funct),
        .rd_addr   (rd_addr),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model_decode(input logic [31:0] w);
        exp_t x;
        logic legal;
        x.rs  = w[25:21];
        x.rt  = w[20:16];
        x.sh  = w[10:6];
        x.fn  = w[5:0];
        legal = (w[31:26] == 6'd0) &&
                (x.fn == F_ADD || x.fn == F_SUB || x.fn == F_SHIFT || x.fn == F_OR);
        x.rd  = legal ? w[15:11] : 5'd0;
        x.ill = !legal;
        return x;
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [4:0] sh, input logic [5:0] fn);
        return {op, rs, rt, rd, sh, fn};
    endfunction

    // Monitor: inputs change just after posedge, so at negedge everything the next
    // edge will act on is stable. Held operands must always equal the architectural
    // register value of the held source field.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_Rs_Data", Rs_Data, 32'd0);
            chk("rst_Rt_Data", Rt_Data, 32'd0);
            chk("rst_fields", {shamt, funct, rd_addr, illegal}, 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            q.delete();
            for (int i = 0; i < 32; i++) regs[i] = '0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (out_valid && q.size() != 0) begin
                e = q[0];
                chk("sb_Rs_Data", Rs_Data, regs[e.rs]);
                chk("sb_Rt_Data", Rt_Data, regs[e.rt]);
                chk("sb_shamt", 32'(shamt), 32'(e.sh));
                chk("sb_funct", 32'(funct), 32'(e.fn));
                chk("sb_rd_addr", 32'(rd_addr), 32'(e.rd));
                chk("sb_illegal", 32'(illegal), 32'(e.ill));
                if (out_ready) void'(q.pop_front());
            end
            if (wb_en && wb_addr != 5'd0) regs[wb_addr] = wb_data;
            if (in_valid && in_ready) q.push_back(model_decode(instr));
        end
    end

    task automatic cyc(input logic iv, input logic [31:0] ins, input logic ordy,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
        in_valid  = iv;
        instr     = ins;
        out_ready = ordy;
        wb_en     = we;
        wb_addr   = wa;
        wb_data   = wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] hold_ins;
        logic [5:0]  op, fn;
        logic [5:0]  legal_fn [4];
        legal_fn[0] = F_ADD; legal_fn[1] = F_SUB; legal_fn[2] = F_SHIFT; legal_fn[3] = F_OR;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Writes, then ADD rd=3 rs=1 rt=2
        cyc(0, 0, 1, 1, 5'd1, 32'd5);
        cyc(0, 0, 1, 1, 5'd2, 32'd3);
        cyc(1, 32'h00221849, 1, 0, 0, 0);
        chk("add_out_valid", 32'(out_valid), 32'd1);
        chk("add_Rs", Rs_Data, 32'd5);
        chk("add_Rt", Rt_Data, 32'd3);
        chk("add_funct", 32'(funct), 32'(F_ADD));
        chk("add_rd", 32'(rd_addr), 32'd3);
        chk("add_illegal", 32'(illegal), 32'd0);

        // Same-edge bypass of r1
        cyc(1, mk(0, 1, 2, 4, 0, F_SUB), 1, 1, 5'd1, 32'hA);
        chk("bypass_Rs", Rs_Data, 32'hA);
        chk("bypass_Rt", Rt_Data, 32'd3);
        cyc(1, mk(0, 1, 2, 5, 0, F_OR), 1, 0, 0, 0);
        chk("after_bypass_Rs", Rs_Data, 32'hA);

        // Stall with a pending instruction, then refresh r2 and release
        hold_ins = mk(0, 3, 3, 6, 0, F_ADD);
        for (int i = 0; i < 3; i++) begin
            cyc(1, hold_ins, 0, 0, 0, 0);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_funct", 32'(funct), 32'(F_OR));
            chk("stall_Rt", Rt_Data, 32'd3);
        end
        cyc(1, hold_ins, 0, 1, 5'd2, 32'd7);
        chk("refresh_Rt", Rt_Data, 32'd7);
        chk("refresh_Rs", Rs_Data, 32'hA);
        cyc(1, hold_ins, 1, 0, 0, 0);
        chk("nobubble_valid", 32'(out_valid), 32'd1);
        chk("nobubble_funct", 32'(funct), 32'(F_ADD));
        chk("nobubble_rd", 32'(rd_addr), 32'd6);

        // Illegal opcode / funct
        cyc(1, mk(6'b000010, 1, 2, 7, 3, F_ADD), 1, 0, 0, 0);
        chk("ill_op_flag", 32'(illegal), 32'd1);
        chk("ill_op_rd", 32'(rd_addr), 32'd0);
        chk("ill_op_funct", 32'(funct), 32'(F_ADD));
        cyc(1, mk(0, 1, 2, 7, 0, 6'b000000), 1, 0, 0, 0);
        chk("ill_fn_flag", 32'(illegal), 32'd1);
        chk("ill_fn_rd", 32'(rd_addr), 32'd0);
        chk("ill_fn_funct", 32'(funct), 32'd0);

        // r0 write ignored
        cyc(0, 0, 1, 1, 5'd0, 32'hFFFF);
        cyc(1, mk(0, 0, 0, 8, 0, F_OR), 1, 1, 5'd0, 32'hFFFF);
        chk("r0_Rs", Rs_Data, 32'd0);
        chk("r0_Rt", Rt_Data, 32'd0);

        // SHIFT with max shamt
        cyc(1, mk(0, 4, 0, 9, 5'd31, F_SHIFT), 1, 0, 0, 0);
        chk("shift_shamt", 32'(shamt), 32'd31);
        chk("shift_funct", 32'(funct), 32'(F_SHIFT));
        cyc(0, 0, 1, 0, 0, 0);
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Four back-to-back
        for (int i = 0; i < 4; i++) begin
            cyc(1, mk(0, 5'(i), 5'(i + 1), 5'(i + 1), 5'(i), F_ADD), 1, 0, 0, 0);
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_rd", 32'(rd_addr), 32'(i + 1));
        end
        cyc(0, 0, 1, 0, 0, 0);
        chk("b2b_end_valid", 32'(out_valid), 32'd0);

        // Async reset while stalled
        cyc(1, mk(0, 1, 2, 10, 0, F_SUB), 0, 0, 0, 0);
        cyc(1, mk(0, 2, 1, 11, 0, F_SUB), 0, 0, 0, 0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        wb_en = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1, mk(0, 1, 2, 12, 0, F_ADD), 1, 0, 0, 0);
        chk("post_rst_Rs", Rs_Data, 32'd0);
        chk("post_rst_Rt", Rt_Data, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
            fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 3)];
            cyc($urandom_range(0, 3) != 0,
                mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom), 5'($urandom), fn),
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 1) == 1,
                5'($urandom_range(0, 7)),
                $urandom);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
        chk("final_drain", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtype_decode_stage.md
Name: rtype_decode_stage

Overview:
- Issue stage directly upstream of the R-type ALU.
- Accepts 32-bit R-type instruction words over a valid/ready handshake, decodes fields, and reads a 32x32 register file with write-through bypass.
- Presents registered Rs_Data/Rt_Data/shamt/funct/destination to the ALU.
- Absorbs the ALU result via a write-back port, closing the execute loop.

Parameters:
- DATA_W, 32, operand/register width.
- REG_AW, 5, register address width; register count is 2**REG_AW.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  instruction word valid.
- in_ready  output  1  stage can accept an instruction this cycle.
- instr  input  32  opcode[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0].
- wb_en  input  1  write-back strobe from ALU side.
- wb_addr  input  REG_AW  write-back destination.
- wb_data  input  DATA_W  write-back value (ALU Rd_Data).
- out_valid  output  1  ALU operands valid.
- out_ready  input  1  ALU side consumes operands this cycle.
- Rs_Data  output  DATA_W  rs operand.
- Rt_Data  output  DATA_W  rt operand.
- shamt  output  5  shift amount.
- funct  output  6  function code.
- rd_addr  output  REG_AW  destination register; 0 means no write.
- illegal  output  1  current output instruction is not a supported R-type.

Behaviour:
- Reset (async, rst_n=0): all register-file entries 0, out_valid=0, Rs_Data=Rt_Data=0, shamt=0, funct=0, rd_addr=0, illegal=0. in_ready=1 after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (single output register, no skid buffer).
  - Accept when in_valid && in_ready.
  - Latency is 1 cycle: accepted at edge N, out_valid=1 after edge N.
  - Output is held stable while out_valid && !out_ready.
  - Simultaneous consume and accept replaces the output with no bubble.
  - Consume without accept clears out_valid.
- Supported funct codes:
  - ADD 6'b001001
  - SUB 6'b001010
  - SHIFT 6'b100001
  - OR 6'b100101
- Legality: legal iff opcode==0 and funct is one of the four supported codes. An illegal instruction is still accepted and passed through with illegal=1, rd_addr forced to 0, funct passed unchanged.
- Register file:
  - Write at rising edge when wb_en && wb_addr!=0.
  - Register 0 always reads 0; writes to it are ignored.
- Read bypass: at accept, if wb_en && wb_addr==rs && rs!=0, Rs_Data takes wb_data in the same cycle; likewise for rt.
- Held-operand refresh: while out_valid && !out_ready, a write-back with wb_addr matching the held rs (or rt) field, nonzero, updates Rs_Data (or Rt_Data) at that edge. The stage stores the rs/rt fields internally for this purpose. If rs==rt, both operands update.
- Write-back is independent of the handshake. Writes occur even when in_valid=0 or the stage is stalled.
- Reset asserted mid-operation drops any held instruction (out_valid=0) and clears the register file.
- No arithmetic in this stage; all fields are zero-extended bit slices.

Decomposition:
- Shared package holds the funct codes (ADD/SUB/SHIFT/OR), R-type opcode 6'b000000, the instruction field bit positions, DATA_W and REG_AW defaults.
- One sub-module, rtype_reg_file: 2 combinational read ports, 1 synchronous write port, r0 hardwired to zero, async active-low reset. Bypass and refresh logic stay in the top module.

Test Plan:
- Reset, then write-back r1=5, r2=3 in consecutive cycles; issue ADD rd=3 rs=1 rt=2 (instr 32'h00221849) -> next cycle out_valid=1, Rs_Data=5, Rt_Data=3, funct=6'b001001, rd_addr=3, illegal=0.
- Same cycle wb_en=1 wb_addr=1 wb_data=32'hA and accept of instruction with rs=1 -> Rs_Data=32'hA (bypass), and r1 reads A afterwards.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable. Then wb r2=7 during the stall -> Rt_Data becomes 7. Then out_ready=1 -> next instruction loaded with no bubble.
- opcode=6'b000010 or funct=6'b000000 -> illegal=1, rd_addr=0, funct passed unchanged. wb to r0 with data 32'hFFFF -> subsequent rs=0 read gives 0.
- SHIFT rs=4 shamt=31 -> shamt=5'd31, funct=6'b100001. Back-to-back 4 instructions with out_ready=1 -> 4 consecutive out_valid cycles.
- Assert rst_n=0 asynchronously while out_valid=1 and stalled -> out_valid=0 immediately, all registers read 0 after release.
